// File: rtl/waypoint_sequencer.sv
// Steps the robot through a small goal-pose table and drives registered sign-magnitude pose errors.
// Pose to error is one registered cycle; there is no backpressure, and table writes are dropped while a mission runs.
module waypoint_sequencer #(
    parameter int          N_WIDTH        = 17,
    parameter int          N_WP           = 4,
    parameter int          ADDR_W         = 2,
    parameter logic [15:0] SETTLE_CYCLES  = 16'd50000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000
) (
    input  logic                WAYPOINT_SEQUENCER_CLOCK_50,
    input  logic                WAYPOINT_SEQUENCER_RESET_InLow,
    input  logic                WAYPOINT_SEQUENCER_WR_EN,
    input  logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_WR_ADDR,
    input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WR_X_InBus,
    input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WR_Y_InBus,
    input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_WR_Z_InBus,
    input  logic [ADDR_W:0]     WAYPOINT_SEQUENCER_WP_COUNT,
    input  logic                WAYPOINT_SEQUENCER_START,
    input  logic                WAYPOINT_SEQUENCER_ABORT,
    input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_X_InBus,
    input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_Y_InBus,
    input  logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_POSE_Z_InBus,
    input  logic                WAYPOINT_SEQUENCER_GOAL_FLAG_InLow,
    output logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_X_OutBus,
    output logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_Y_OutBus,
    output logic [N_WIDTH-1:0]  WAYPOINT_SEQUENCER_ERR_Z_OutBus,
    output logic                WAYPOINT_SEQUENCER_BUSY,
    output logic [ADDR_W-1:0]   WAYPOINT_SEQUENCER_WP_INDEX,
    output logic                WAYPOINT_SEQUENCER_DONE,
    output logic                WAYPOINT_SEQUENCER_FAULT
);

    localparam int              MAG_W        = N_WIDTH - 1;
    localparam logic [ADDR_W:0] WP_MAX       = (ADDR_W + 1)'(N_WP);
    localparam logic [15:0]     SETTLE_LAST  = SETTLE_CYCLES - 16'd1;
    localparam logic [31:0]     TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TRACK,
        NEXT,
        DONE_ST,
        FAULT_ST
    } state_t;

    logic clk;
    logic rst_n;
    assign clk   = WAYPOINT_SEQUENCER_CLOCK_50;
    assign rst_n = WAYPOINT_SEQUENCER_RESET_InLow;

    state_t              state, state_d;
    logic [N_WIDTH-1:0]  tbl_x [N_WP];
    logic [N_WIDTH-1:0]  tbl_y [N_WP];
    logic [N_WIDTH-1:0]  tbl_z [N_WP];
    logic [N_WIDTH-1:0]  goal_x, goal_y, goal_z;
    logic [N_WIDTH-1:0]  sel_x, sel_y, sel_z;
    logic [N_WIDTH-1:0]  err_x, err_y, err_z;
    logic [ADDR_W-1:0]   wp_index;
    logic [ADDR_W:0]     wp_total;
    logic [ADDR_W:0]     cnt_in;
    logic [ADDR_W:0]     idx_p1;
    logic [15:0]         settle_cnt;
    logic [31:0]         tmo_cnt;
    logic                busy;

    // Both operands widened to two's complement so -0 collapses to 0 before subtracting.
    function automatic logic [N_WIDTH-1:0] sm_sub(input logic [N_WIDTH-1:0] g,
                                                  input logic [N_WIDTH-1:0] p);
        logic [MAG_W+1:0] a;
        logic [MAG_W+1:0] b;
        logic [MAG_W+2:0] d;
        logic [MAG_W+2:0] m;
        logic [MAG_W-1:0] mag;
        a   = g[MAG_W] ? ({(MAG_W+2){1'b0}} - {2'b00, g[MAG_W-1:0]}) : {2'b00, g[MAG_W-1:0]};
        b   = p[MAG_W] ? ({(MAG_W+2){1'b0}} - {2'b00, p[MAG_W-1:0]}) : {2'b00, p[MAG_W-1:0]};
        d   = {a[MAG_W+1], a} - {b[MAG_W+1], b};
        m   = d[MAG_W+2] ? ({(MAG_W+3){1'b0}} - d) : d;
        mag = (|m[MAG_W+2:MAG_W]) ? {MAG_W{1'b1}} : m[MAG_W-1:0];
        return {d[MAG_W+2] & (|mag), mag};
    endfunction

    assign busy   = (state == LOAD) || (state == TRACK) || (state == NEXT);
    assign cnt_in = (WAYPOINT_SEQUENCER_WP_COUNT > WP_MAX) ? WP_MAX : WAYPOINT_SEQUENCER_WP_COUNT;
    assign idx_p1 = {1'b0, wp_index} + {{ADDR_W{1'b0}}, 1'b1};

    // LOAD reads the table directly so its first errors land at the end of LOAD.
    assign sel_x = (state == LOAD) ? tbl_x[wp_index] : goal_x;
    assign sel_y = (state == LOAD) ? tbl_y[wp_index] : goal_y;
    assign sel_z = (state == LOAD) ? tbl_z[wp_index] : goal_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     if (WAYPOINT_SEQUENCER_START) state_d = (cnt_in == '0) ? DONE_ST : LOAD;
            LOAD:     state_d = TRACK;
            TRACK: begin
                if (!WAYPOINT_SEQUENCER_GOAL_FLAG_InLow && settle_cnt == SETTLE_LAST)
                    state_d = NEXT;
                else if (tmo_cnt == TIMEOUT_LAST)
                    state_d = FAULT_ST;
            end
            NEXT:     state_d = (idx_p1 >= wp_total) ? DONE_ST : LOAD;
            DONE_ST:  state_d = IDLE;
            FAULT_ST: if (WAYPOINT_SEQUENCER_START) state_d = LOAD;
            default:  state_d = IDLE;
        endcase
        if (WAYPOINT_SEQUENCER_ABORT) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_WP; i++) begin
                tbl_x[i] <= '0;
                tbl_y[i] <= '0;
                tbl_z[i] <= '0;
            end
            goal_x     <= '0;
            goal_y     <= '0;
            goal_z     <= '0;
            err_x      <= '0;
            err_y      <= '0;
            err_z      <= '0;
            wp_index   <= '0;
            wp_total   <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            if (WAYPOINT_SEQUENCER_WR_EN && !busy) begin
                tbl_x[WAYPOINT_SEQUENCER_WR_ADDR] <= WAYPOINT_SEQUENCER_WR_X_InBus;
                tbl_y[WAYPOINT_SEQUENCER_WR_ADDR] <= WAYPOINT_SEQUENCER_WR_Y_InBus;
                tbl_z[WAYPOINT_SEQUENCER_WR_ADDR] <= WAYPOINT_SEQUENCER_WR_Z_InBus;
            end

            if ((state == IDLE || state == FAULT_ST) && (state_d == LOAD || state_d == DONE_ST)) begin
                wp_index <= '0;
                wp_total <= cnt_in;
            end else if (state == NEXT && state_d == LOAD) begin
                wp_index <= wp_index + ADDR_W'(1);
            end

            if (state == LOAD) begin
                goal_x     <= tbl_x[wp_index];
                goal_y     <= tbl_y[wp_index];
                goal_z     <= tbl_z[wp_index];
                settle_cnt <= '0;
                tmo_cnt    <= '0;
            end else if (state == TRACK) begin
                settle_cnt <= WAYPOINT_SEQUENCER_GOAL_FLAG_InLow ? 16'd0 : settle_cnt + 16'd1;
                tmo_cnt    <= tmo_cnt + 32'd1;
            end

            // Errors are nonzero only while TRACK is the registered state, so any exit zeroes them at once.
            if (state_d == TRACK) begin
                err_x <= sm_sub(sel_x, WAYPOINT_SEQUENCER_POSE_X_InBus);
                err_y <= sm_sub(sel_y, WAYPOINT_SEQUENCER_POSE_Y_InBus);
                err_z <= sm_sub(sel_z, WAYPOINT_SEQUENCER_POSE_Z_InBus);
            end else begin
                err_x <= '0;
                err_y <= '0;
                err_z <= '0;
            end
        end
    end

    assign WAYPOINT_SEQUENCER_ERR_X_OutBus = err_x;
    assign WAYPOINT_SEQUENCER_ERR_Y_OutBus = err_y;
    assign WAYPOINT_SEQUENCER_ERR_Z_OutBus = err_z;
    assign WAYPOINT_SEQUENCER_BUSY         = busy;
    assign WAYPOINT_SEQUENCER_WP_INDEX     = wp_index;
    assign WAYPOINT_SEQUENCER_DONE         = (state == DONE_ST);
    assign WAYPOINT_SEQUENCER_FAULT        = (state == FAULT_ST);

endmodule

// File: tb/tb_waypoint_sequencer.sv
// Randomized bench for waypoint_sequencer against a procedural mission-level reference model.
// Settle time is 4 cycles and timeout 20 cycles so missions stay short.
module tb_waypoint_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [16:0] wr_x = '0, wr_y = '0, wr_z = '0;
    logic [2:0]  wp_count = '0;
    logic        start = 1'b0, abort = 1'b0;
    logic [16:0] px = '0, py = '0, pz = '0;
    logic        flag = 1'b1;
    logic [16:0] ex, ey, ez;
    logic        busy, done, fault;
    logic [1:0]  idx;

    always #10 clk = ~clk;

    waypoint_sequencer #(
        .N_WIDTH(17), .N_WP(4), .ADDR_W(2),
        .SETTLE_CYCLES(16'd4), .TIMEOUT_CYCLES(32'd20)
    ) dut (
        .WAYPOINT_SEQUENCER_CLOCK_50       (clk),
        .WAYPOINT_SEQUENCER_RESET_InLow    (rst_n),
        .WAYPOINT_SEQUENCER_WR_EN          (wr_en),
        .WAYPOINT_SEQUENCER_WR_ADDR        (wr_addr),
        .WAYPOINT_SEQUENCER_WR_X_InBus     (wr_x),
        .WAYPOINT_SEQUENCER_WR_Y_InBus     (wr_y),
        .WAYPOINT_SEQUENCER_WR_Z_InBus     (wr_z),
        .WAYPOINT_SEQUENCER_WP_COUNT       (wp_count),
        .WAYPOINT_SEQUENCER_START          (start),
        .WAYPOINT_SEQUENCER_ABORT          (abort),
        .WAYPOINT_SEQUENCER_POSE_X_InBus   (px),
        .WAYPOINT_SEQUENCER_POSE_Y_InBus   (py),
        .WAYPOINT_SEQUENCER_POSE_Z_InBus   (pz),
        .WAYPOINT_SEQUENCER_GOAL_FLAG_InLow(flag),
        .WAYPOINT_SEQUENCER_ERR_X_OutBus   (ex),
        .WAYPOINT_SEQUENCER_ERR_Y_OutBus   (ey),
        .WAYPOINT_SEQUENCER_ERR_Z_OutBus   (ez),
        .WAYPOINT_SEQUENCER_BUSY           (busy),
        .WAYPOINT_SEQUENCER_WP_INDEX       (idx),
        .WAYPOINT_SEQUENCER_DONE           (done),
        .WAYPOINT_SEQUENCER_FAULT          (fault)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [16:0] gx [4];
    logic [16:0] gy [4];
    logic [16:0] gz [4];
    bit          m_fault = 1'b0;
    bit          rand_pose = 1'b0;
    int          flag_mode = 1;
    bit          flag_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] st();
        return {busy, done, fault, idx};
    endfunction

    function automatic int sm2i(input logic [16:0] v);
        int m;
        m = int'(v[15:0]);
        return v[16] ? -m : m;
    endfunction

    function automatic logic [16:0] ref_err(input logic [16:0] g, input logic [16:0] p);
        int d, m;
        logic [16:0] r;
        d = sm2i(g) - sm2i(p);
        m = (d < 0) ? -d : d;
        if (m > 65535) m = 65535;
        r[15:0] = m[15:0];
        r[16]   = (d < 0);
        return r;
    endfunction

    function automatic logic [50:0] ref_all(input int w);
        return {ref_err(gx[w], px), ref_err(gy[w], py), ref_err(gz[w], pz)};
    endfunction

    function automatic logic [16:0] rnd_sm();
        logic [16:0] v;
        v = 17'($urandom);
        if ($urandom_range(0, 15) == 0) v = 17'h10000;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pose();
        if (rand_pose) begin
            px = rnd_sm();
            py = rnd_sm();
            pz = rnd_sm();
        end
    endtask

    function automatic bit next_flag();
        if (flag_q.size() > 0) return flag_q.pop_front();
        if (flag_mode == 1) return 1'b0;
        if (flag_mode == 2) return 1'b1;
        return ($urandom_range(0, 9) < 3);
    endfunction

    task automatic wr(input int a, input logic [16:0] x, input logic [16:0] y, input logic [16:0] z);
        wr_en = 1'b1; wr_addr = a[1:0]; wr_x = x; wr_y = y; wr_z = z;
        tick();
        wr_en = 1'b0;
        gx[a] = x; gy[a] = y; gz[a] = z;
    endtask

    // Drives one mission from IDLE or FAULT and checks every cycle against the mission rules.
    task automatic run_mission(input int cnt, input bit wr0);
        int   n, run, cyc;
        bit   f;
        logic [4:0] e;
        n = (cnt > 4) ? 4 : cnt;
        wp_count = cnt[2:0];
        start = 1'b1;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 2'd0;
            wr_x = rnd_sm(); wr_y = rnd_sm(); wr_z = rnd_sm();
            gx[0] = wr_x; gy[0] = wr_y; gz[0] = wr_z;
        end
        tick();
        start = 1'b0; wr_en = 1'b0;
        if (n == 0 && !m_fault) begin
            chk("done_empty", {61'd0, st()[4:2]}, 64'b010);
            chk("err_empty", {ex, ey, ez}, 64'd0);
            tick();
            chk("idle_empty", {61'd0, st()[4:2]}, 64'b000);
            return;
        end
        m_fault = 1'b0;
        for (int w = 0; w < n; w++) begin
            e = {3'b100, w[1:0]};
            chk("load", st(), e);
            set_pose();
            flag = next_flag();
            tick();
            chk("track_st", st(), e);
            chk("err_first", {ex, ey, ez}, ref_all(w));
            run = 0;
            cyc = 0;
            while (1) begin
                f = next_flag();
                flag = f;
                set_pose();
                tick();
                cyc++;
                run = f ? 0 : run + 1;
                if (run == 4) break;
                if (cyc == 20) begin
                    chk("fault_st", st(), {3'b001, w[1:0]});
                    chk("err_fault", {ex, ey, ez}, 64'd0);
                    m_fault = 1'b1;
                    flag = 1'b1;
                    return;
                end
                chk("track_st", st(), e);
                chk("err_track", {ex, ey, ez}, ref_all(w));
            end
            chk("next_st", st(), e);
            chk("err_next", {ex, ey, ez}, 64'd0);
            flag = 1'b1;
            tick();
        end
        chk("done_st", {61'd0, st()[4:2]}, 64'b010);
        chk("err_done", {ex, ey, ez}, 64'd0);
        tick();
        chk("idle_st", {61'd0, st()[4:2]}, 64'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            gx[i] = '0; gy[i] = '0; gz[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_st", st(), 5'd0);
        chk("rst_err", {ex, ey, ez}, 64'd0);
        rst_n = 1'b1;
        tick();

        // +50 cm goal from a zero pose
        wr(0, 17'h00000, 17'h03200, 17'h00000);
        px = '0; py = '0; pz = '0;
        flag_mode = 1;
        run_mission(1, 1'b0);

        // negative error and no -0 result
        wr(0, 17'h00000, 17'h00A00, 17'h00000);
        py = 17'h03C00;
        run_mission(1, 1'b0);
        py = 17'h00A00;
        run_mission(1, 1'b0);

        // interrupted settle run
        wr(1, rnd_sm(), rnd_sm(), rnd_sm());
        rand_pose = 1'b1;
        flag_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        run_mission(2, 1'b0);

        // three waypoints, then clamped count
        wr(2, rnd_sm(), rnd_sm(), rnd_sm());
        run_mission(3, 1'b0);
        wr(3, rnd_sm(), rnd_sm(), rnd_sm());
        run_mission(7, 1'b0);

        // timeout, then restart from the fault state
        flag_mode = 2;
        run_mission(1, 1'b0);
        chk("fault_sticky", {63'd0, fault}, 64'd1);
        tick();
        chk("fault_hold", st(), 5'b00100);
        flag_mode = 1;
        run_mission(1, 1'b0);

        // abort beats start mid-track
        flag = 1'b1;
        wp_count = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_st", {61'd0, st()[4:2]}, 64'b000);
        chk("abort_err", {ex, ey, ez}, 64'd0);
        tick();
        chk("abort_nodone", {61'd0, st()[4:2]}, 64'b000);

        // a write while busy is dropped
        wp_count = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 2'd1; wr_x = rnd_sm(); wr_y = rnd_sm(); wr_z = rnd_sm();
        tick();
        wr_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort2_st", {61'd0, st()[4:2]}, 64'b000);
        run_mission(2, 1'b0);

        // write and start in the same cycle
        run_mission(1, 1'b1);

        // reset mid-mission clears state, outputs and table
        flag = 1'b1;
        wp_count = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_st", st(), 5'd0);
        chk("arst_err", {ex, ey, ez}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gx[i] = '0; gy[i] = '0; gz[i] = '0;
        end
        m_fault = 1'b0;
        run_mission(4, 1'b0);

        // randomized missions
        flag_mode = 0;
        for (int k = 0; k < 14; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                wr(int'($urandom_range(0, 3)), rnd_sm(), rnd_sm(), rnd_sm());
            if (m_fault)
                run_mission(int'($urandom_range(1, 7)), bit'($urandom_range(0, 1)));
            else
                run_mission(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
